// File: rtl/spart_mmio_fifo_bridge_if.sv
// CPU-side memory-mapped I/O port of the SPART bridge.
// The CPU drives a request and holds it until the bridge returns a one-cycle ready pulse.
interface spart_mmio_fifo_bridge_if #(
   parameter int ADDR_W = 28
);
   logic              io_valid_data;
   logic              io_rw_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       io_wr_data;
   logic [31:0]       io_rd_data;
   logic              io_ready_data;

   // CPU side: issues requests, receives completion and read data
   modport master (
      output io_valid_data, io_rw_data, mem_addr, io_wr_data,
      input  io_rd_data, io_ready_data
   );

   // Bridge side: accepts requests, returns completion and read data
   modport slave (
      input  io_valid_data, io_rw_data, mem_addr, io_wr_data,
      output io_rd_data, io_ready_data
   );
endinterface

// File: rtl/spart_mmio_fifo_bridge.sv
// Memory-mapped bridge between the CPU I/O port and a byte-level SPART core.
// Four registers: DATA (FIFO access), STATUS, CTRL (irq enables, clear/flush strobes), BAUD.
// TX and RX bytes are buffered in power-of-two FIFOs; the TX head is presented show-ahead.
module spart_mmio_fifo_bridge #(
   parameter int              ADDR_W    = 28,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 28'h800_0000,
   parameter int              TX_DEPTH  = 16,
   parameter int              RX_DEPTH  = 16,
   parameter logic [15:0]     DIV_RESET = 16'd325
) (
   input  logic                     clk,
   input  logic                     rst,
   spart_mmio_fifo_bridge_if.slave  bus,
   output logic [7:0]               tx_data,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   input  logic [7:0]               rx_data,
   input  logic                     rx_valid,
   output logic [15:0]              baud_div,
   output logic                     irq
);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_CW = TX_AW + 1;
   localparam int RX_CW = RX_AW + 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              rw_reg;
   logic [15:0]       wdata_reg;
   logic [31:0]       rd_data_reg;
   logic              ready_reg;
   logic [2:0]        en_reg;
   logic [15:0]       baud_reg;
   logic              overrun_reg;
   logic              irq_reg;

   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
   logic [TX_CW-1:0] tx_count_reg;
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
   logic [RX_CW-1:0] rx_count_reg;

   // Address decode on the latched request; subtraction wraps so addresses below BASE miss too
   logic [ADDR_W-1:0] offs;
   logic in_range, in_exec;
   logic wr_data_acc, rd_data_acc, wr_ctrl_acc, wr_baud_acc;
   assign offs        = addr_reg - BASE_ADDR;
   assign in_range    = (offs < ADDR_W'(4));
   assign in_exec     = (state_reg == EXEC);
   assign wr_data_acc = in_exec & in_range & rw_reg  & (offs[1:0] == 2'd0);
   assign rd_data_acc = in_exec & in_range & !rw_reg & (offs[1:0] == 2'd0);
   assign wr_ctrl_acc = in_exec & in_range & rw_reg  & (offs[1:0] == 2'd2);
   assign wr_baud_acc = in_exec & in_range & rw_reg  & (offs[1:0] == 2'd3);

   // FIFO status and per-cycle push/pop/flush strobes
   logic tx_full, tx_empty, rx_full, rx_nonempty;
   logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
   logic exec_stall, overrun_set, overrun_clr;
   assign tx_full     = (tx_count_reg == TX_CW'(TX_DEPTH));
   assign tx_empty    = (tx_count_reg == '0);
   assign rx_full     = (rx_count_reg == RX_CW'(RX_DEPTH));
   assign rx_nonempty = (rx_count_reg != '0);
   assign tx_pop      = tx_valid & tx_ready;
   // A slot freed by the SPART in the same cycle is usable by a blocked write
   assign tx_push     = wr_data_acc & (!tx_full | tx_pop);
   assign exec_stall  = wr_data_acc & tx_full & !tx_pop;
   assign tx_flush    = wr_ctrl_acc & wdata_reg[10];
   assign rx_flush    = wr_ctrl_acc & wdata_reg[9];
   assign rx_pop      = rd_data_acc & rx_nonempty;
   assign rx_push     = rx_valid & !rx_flush & (!rx_full | rx_pop);
   assign overrun_set = rx_valid & !rx_flush & rx_full & !rx_pop;
   assign overrun_clr = wr_ctrl_acc & wdata_reg[8];

   logic [7:0]  tx_count8, rx_count8;
   logic [31:0] status_word, rd_value;
   assign tx_count8   = 8'(tx_count_reg);
   assign rx_count8   = 8'(rx_count_reg);
   assign status_word = {8'd0, tx_count8, rx_count8, 4'd0,
                         tx_empty, overrun_reg, !tx_full, rx_nonempty};

   // Read value for the access in EXEC; misses and writes return zero
   always_comb begin
      rd_value = '0;
      if (!rw_reg && in_range) begin
         case (offs[1:0])
            2'd0:    rd_value = rx_nonempty ? {24'd0, rx_mem[rx_rd_ptr_reg]} : 32'h0000_0100;
            2'd1:    rd_value = status_word;
            2'd2:    rd_value = {29'd0, en_reg};
            default: rd_value = {16'd0, baud_reg};
         endcase
      end
   end

   // Request FSM: latch in IDLE, perform in EXEC (stalling on a full TX), pulse ready in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         rw_reg      <= 1'b0;
         wdata_reg   <= '0;
         rd_data_reg <= '0;
         ready_reg   <= 1'b0;
         en_reg      <= '0;
         baud_reg    <= DIV_RESET;
      end else begin
         case (state_reg)
            IDLE: begin
               ready_reg <= 1'b0;
               if (bus.io_valid_data) begin
                  addr_reg  <= bus.mem_addr;
                  rw_reg    <= bus.io_rw_data;
                  wdata_reg <= bus.io_wr_data[15:0];
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               if (!exec_stall) begin
                  rd_data_reg <= rd_value;
                  ready_reg   <= 1'b1;
                  state_reg   <= RESP;
                  if (wr_ctrl_acc) en_reg   <= wdata_reg[2:0];
                  if (wr_baud_acc) baud_reg <= wdata_reg;
               end
            end
            RESP: begin
               ready_reg <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // TX FIFO pointers and occupancy; flush returns it to empty
   always_ff @(posedge clk) begin
      if (rst || tx_flush) begin
         tx_wr_ptr_reg <= '0;
         tx_rd_ptr_reg <= '0;
         tx_count_reg  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
         if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
         if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + 1'b1;
         else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - 1'b1;
      end
   end

   // TX storage write
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_ptr_reg] <= wdata_reg[7:0];
   end

   // RX FIFO pointers, occupancy and sticky overrun; flush wins over a same-cycle push
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr_reg <= '0;
         rx_rd_ptr_reg <= '0;
         rx_count_reg  <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         overrun_reg <= (overrun_reg & !overrun_clr) | overrun_set;
         if (rx_flush) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
         end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + 1'b1;
            else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - 1'b1;
         end
      end
   end

   // RX storage write
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr_reg] <= rx_data;
   end

   // Interrupt registered one cycle behind its enabled sources
   always_ff @(posedge clk) begin
      if (rst) irq_reg <= 1'b0;
      else     irq_reg <= (en_reg[0] & rx_nonempty) | (en_reg[1] & tx_empty) | (en_reg[2] & overrun_reg);
   end

   assign bus.io_rd_data    = rd_data_reg;
   assign bus.io_ready_data = ready_reg;
   assign tx_valid          = !tx_empty;
   assign tx_data           = tx_mem[tx_rd_ptr_reg];
   assign baud_div          = baud_reg;
   assign irq               = irq_reg;
endmodule
